// File: rtl/theta_step.sv
// Keccak theta step, slice-serial: 64 parity cycles, then 64 apply cycles, then a one-cycle Ready pulse.
// Define THETA_BUSY_EN to add the registered 'busy' status output.
module theta_step (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] mem_in  [0:63],
  output logic        Ready,
  output logic [24:0] mem_out [0:63]
`ifdef THETA_BUSY_EN
  ,
  output logic        busy
`endif
);

  typedef enum logic [1:0] {IDLE, PARITY, APPLY, DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [24:0] r_buf [0:63];
  logic [4:0]  r_par [0:63];

  logic [24:0] w_slice;
  logic [4:0]  w_colPar;
  logic [4:0]  w_cur;
  logic [4:0]  w_prev;
  logic [4:0]  w_theta;
  logic [24:0] w_word;

  // Row y of a slice occupies bits [5y+4:5y], so column parity is the XOR of the five rows.
  assign w_slice  = r_buf[r_cnt];
  assign w_colPar = w_slice[4:0] ^ w_slice[9:5] ^ w_slice[14:10] ^ w_slice[19:15] ^ w_slice[24:20];

  // Bit x of w_theta is C[x-1][z] ^ C[x+1][z-1]; the 6-bit index wraps slice 0 onto 63.
  assign w_cur   = r_par[r_cnt];
  assign w_prev  = r_par[r_cnt - 6'd1];
  assign w_theta = {w_cur[3:0], w_cur[4]} ^ {w_prev[0], w_prev[4:1]};
  assign w_word  = w_slice ^ {5{w_theta}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      Ready   <= 1'b0;
`ifdef THETA_BUSY_EN
      busy    <= 1'b0;
`endif
      for (int z = 0; z < 64; z++) begin
        mem_out[z] <= '0;
        r_buf[z]   <= '0;
        r_par[z]   <= '0;
      end
    end else begin
      Ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int z = 0; z < 64; z++) begin
              r_buf[z] <= mem_in[z];
            end
            r_cnt   <= '0;
            r_state <= PARITY;
`ifdef THETA_BUSY_EN
            busy    <= 1'b1;
`endif
          end
        end
        PARITY: begin
          r_par[r_cnt] <= w_colPar;
          r_cnt        <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_state <= APPLY;
          end
        end
        APPLY: begin
          mem_out[r_cnt] <= w_word;
          r_cnt          <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_state <= DONE;
            Ready   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
`ifdef THETA_BUSY_EN
          busy    <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
